// File: rtl/round_constant_inv_gen_if.sv
// Handshake bundle between the inverse-round controller (master) and the
// reverse round-constant source (slave).
interface round_constant_inv_gen_if;
  logic        start;
  logic        round_const_ena;
  logic        busy;
  logic        valid;
  logic        last;
  logic        done;
  logic [4:0]  round_idx;
  logic [31:0] round_constant;

  modport master (
    output start, round_const_ena,
    input  busy, valid, last, done, round_idx, round_constant
  );

  modport slave (
    input  start, round_const_ena,
    output busy, valid, last, done, round_idx, round_constant
  );
endinterface

// File: rtl/round_constant_inv_gen.sv
// uBlock decryption round-constant source: replays the encryption LFSR constants
// from round ROUNDS-1 down to 0. Define ROUND_CONST_PRECOMP_EN to skip the SEEK phase.
module round_constant_inv_gen #(
  parameter int          ROUNDS = 16,
  parameter logic [7:0]  INIT   = 8'h6C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  round_constant_inv_gen_if.slave  bus
);

  localparam int          NUM_LANES = 4;
  localparam logic [4:0]  LAST_IDX  = 5'(ROUNDS - 1);
  localparam logic [31:0] LANE_MASK = 32'h40541105;

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[6] ^ s[2] ^ s[1]};
  endfunction

  function automatic logic [7:0] prv(input logic [7:0] s);
    return {s[0] ^ s[7] ^ s[3] ^ s[2], s[7:1]};
  endfunction

`ifdef ROUND_CONST_PRECOMP_EN
  // End-of-schedule LFSR state folded to a constant at elaboration.
  function automatic logic [7:0] seek_final();
    logic [7:0] s;
    s = INIT;
    for (int i = 0; i < ROUNDS; i++) s = nxt(s);
    return s;
  endfunction

  localparam logic [7:0] FINAL_STATE = seek_final();

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, RUN = 2'd2} state_t;
`endif

  state_t      state;
  logic [7:0]  lfsr;
  logic [4:0]  cnt;
  logic        done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr   <= 8'h00;
      cnt    <= 5'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef ROUND_CONST_PRECOMP_EN
            lfsr  <= FINAL_STATE;
            cnt   <= LAST_IDX;
            state <= RUN;
`else
            lfsr  <= INIT;
            cnt   <= 5'd0;
            state <= SEEK;
`endif
          end
        end
`ifndef ROUND_CONST_PRECOMP_EN
        SEEK: begin
          lfsr <= nxt(lfsr);
          if (cnt == LAST_IDX) begin
            cnt   <= LAST_IDX;
            state <= RUN;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
`endif
        RUN: begin
          if (bus.round_const_ena) begin
            lfsr <= prv(lfsr);
            // Index 0 is the final constant; stay at 0 rather than wrap.
            if (cnt == 5'd0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic valid;
  assign valid          = (state == RUN);
  assign bus.valid      = valid;
  assign bus.busy       = (state != IDLE);
  assign bus.last       = valid && (cnt == 5'd0);
  assign bus.round_idx  = valid ? cnt : 5'd0;
  assign bus.done       = done_q;

  // Each byte lane is the LFSR state xored with its own lane constant.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign bus.round_constant[8*g +: 8] = valid ? (lfsr ^ LANE_MASK[8*g +: 8]) : 8'h00;
  end

endmodule

// File: tb/tb_round_constant_inv_gen.sv
// Directed bench: ROUNDS=3 instance for hand-computed vectors, ROUNDS=16 instance
// checked against a forward LFSR model.
module tb_round_constant_inv_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3_n, rst16_n;

  round_constant_inv_gen_if b3 ();
  round_constant_inv_gen_if b16 ();

  round_constant_inv_gen #(.ROUNDS(3))  dut3  (.clk(clk), .rst_n(rst3_n),  .bus(b3.slave));
  round_constant_inv_gen #(.ROUNDS(16)) dut16 (.clk(clk), .rst_n(rst16_n), .bus(b16.slave));

`ifdef ROUND_CONST_PRECOMP_EN
  localparam int SEEK3  = 0;
  localparam int SEEK16 = 0;
`else
  localparam int SEEK3  = 3;
  localparam int SEEK16 = 16;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Forward model: constant used by encryption round k.
  function automatic logic [31:0] exp_const(input int k);
    logic [7:0] s;
    s = 8'h6C;
    for (int i = 0; i <= k; i++) s = {s[6:0], s[7] ^ s[6] ^ s[2] ^ s[1]};
    return {s, s, s, s} ^ 32'h40541105;
  endfunction

  initial begin
    rst3_n = 1'b0; rst16_n = 1'b0;
    b3.start = 1'b0;  b3.round_const_ena = 1'b0;
    b16.start = 1'b0; b16.round_const_ena = 1'b0;
    #12;
    // Reset state
    chk("rst_busy",  32'(b3.busy),  32'd0);
    chk("rst_valid", 32'(b3.valid), 32'd0);
    chk("rst_done",  32'(b3.done),  32'd0);
    chk("rst_last",  32'(b3.last),  32'd0);
    chk("rst_idx",   32'(b3.round_idx), 32'd0);
    chk("rst_const", b3.round_constant, 32'h0);
    tick;
    rst3_n = 1'b1; rst16_n = 1'b1;
    tick;

    // T1: ena held high from start (ignored until RUN)
    b3.start = 1'b1;
    tick;
    b3.start = 1'b0;
    b3.round_const_ena = 1'b1;
    chk("t1_busy", 32'(b3.busy), 32'd1);
    repeat (SEEK3) tick;
    chk("t1_c2",   b3.round_constant, 32'h21357064);
    chk("t1_i2",   32'(b3.round_idx), 32'd2);
    chk("t1_l2",   32'(b3.last), 32'd0);
    tick;
    chk("t1_c1",   b3.round_constant, 32'hF0E4A1B5);
    chk("t1_i1",   32'(b3.round_idx), 32'd1);
    tick;
    chk("t1_c0",   b3.round_constant, 32'h988CC9DD);
    chk("t1_i0",   32'(b3.round_idx), 32'd0);
    chk("t1_l0",   32'(b3.last), 32'd1);
    tick;
    chk("t1_done", 32'(b3.done), 32'd1);
    chk("t1_vld",  32'(b3.valid), 32'd0);
    chk("t1_cz",   b3.round_constant, 32'h0);
    chk("t1_busy0", 32'(b3.busy), 32'd0);
    tick;
    chk("t1_done0", 32'(b3.done), 32'd0);
    b3.round_const_ena = 1'b0;

    // T3: ena pattern 1,0,0,1
    b3.start = 1'b1;
    tick;
    b3.start = 1'b0;
    repeat (SEEK3) tick;
    chk("t3_c2", b3.round_constant, 32'h21357064);
    b3.round_const_ena = 1'b1; tick;
    chk("t3_c1a", b3.round_constant, 32'hF0E4A1B5);
    b3.round_const_ena = 1'b0; tick;
    chk("t3_c1b", b3.round_constant, 32'hF0E4A1B5);
    chk("t3_i1b", 32'(b3.round_idx), 32'd1);
    tick;
    chk("t3_c1c", b3.round_constant, 32'hF0E4A1B5);
    chk("t3_done_hold", 32'(b3.done), 32'd0);
    b3.round_const_ena = 1'b1; tick;
    chk("t3_c0", b3.round_constant, 32'h988CC9DD);
    tick;
    chk("t3_done", 32'(b3.done), 32'd1);
    b3.round_const_ena = 1'b0;
    tick;

    // T4: start during SEEK and on the final consume is ignored
    b3.start = 1'b1;
    tick;
    repeat (SEEK3) tick;
    b3.start = 1'b0;
    chk("t4_c2", b3.round_constant, 32'h21357064);
    chk("t4_i2", 32'(b3.round_idx), 32'd2);
    b3.round_const_ena = 1'b1;
    tick; tick;
    chk("t4_i0", 32'(b3.round_idx), 32'd0);
    b3.start = 1'b1;
    tick;
    b3.start = 1'b0;
    b3.round_const_ena = 1'b0;
    chk("t4_done", 32'(b3.done), 32'd1);
    chk("t4_busy", 32'(b3.busy), 32'd0);
    tick;
    chk("t4_idle_vld", 32'(b3.valid), 32'd0);
    chk("t4_idle_busy", 32'(b3.busy), 32'd0);
    b3.start = 1'b1;
    tick;
    b3.start = 1'b0;
    repeat (SEEK3) tick;
    chk("t4_re_c2", b3.round_constant, 32'h21357064);
    chk("t4_re_i2", 32'(b3.round_idx), 32'd2);
    b3.round_const_ena = 1'b1;
    repeat (3) tick;
    b3.round_const_ena = 1'b0;
    tick;

    // T2: full 16-round sequence against forward model
    b16.start = 1'b1;
    tick;
    b16.start = 1'b0;
    repeat (SEEK16) tick;
    b16.round_const_ena = 1'b1;
    for (int k = 15; k >= 0; k--) begin
      chk("t2_const", b16.round_constant, exp_const(k));
      chk("t2_idx",   32'(b16.round_idx), 32'(k));
      chk("t2_last",  32'(b16.last), (k == 0) ? 32'd1 : 32'd0);
      tick;
    end
    chk("t2_done", 32'(b16.done), 32'd1);
    b16.round_const_ena = 1'b0;
    tick;
    chk("t2_done0", 32'(b16.done), 32'd0);

    // T5: async reset mid-RUN at idx 7, then full replay
    b16.start = 1'b1;
    tick;
    b16.start = 1'b0;
    repeat (SEEK16) tick;
    b16.round_const_ena = 1'b1;
    repeat (8) tick;
    b16.round_const_ena = 1'b0;
    chk("t5_i7", 32'(b16.round_idx), 32'd7);
    chk("t5_c7", b16.round_constant, exp_const(7));
    rst16_n = 1'b0;
    #1;
    chk("t5_rst_vld",   32'(b16.valid), 32'd0);
    chk("t5_rst_busy",  32'(b16.busy), 32'd0);
    chk("t5_rst_idx",   32'(b16.round_idx), 32'd0);
    chk("t5_rst_const", b16.round_constant, 32'h0);
    #2;
    rst16_n = 1'b1;
    tick;
    b16.start = 1'b1;
    tick;
    b16.start = 1'b0;
    repeat (SEEK16) tick;
    b16.round_const_ena = 1'b1;
    for (int k = 15; k >= 0; k--) begin
      chk("t5_const", b16.round_constant, exp_const(k));
      chk("t5_idx",   32'(b16.round_idx), 32'(k));
      tick;
    end
    chk("t5_done", 32'(b16.done), 32'd1);
    b16.round_const_ena = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
